rx_packet_ctrl: RTL and testbench
=================================

Name: rx_packet_ctrl

Overview:
- Receive-side sequencer for the DP/DM -> NRZI -> bit-unstuff -> CRC16 decode chain.
- On request from the protocol handler, it arms the chain with a one-cycle rec_start pulse and times out if no packet arrives.
- It deserialises the bits leaving the CRC16 stage into PID and payload, then checks PID integrity, expected packet class, length and CRC residue.
- It reports one done pulse with a status code.

Parameters:
- TIMEOUT_CYCLES, 255: clock cycles allowed from rec_start to the first valid bit before a timeout.
- DATA_BITS, 64: exact payload length of a DATA0/DATA1 packet, excluding CRC.

Ports:
- clock  input  1  system clock (one bit-time per cycle)
- reset_n  input  1  reset; asynchronous, active-low
- rx_req  input  1  start one receive; sampled only in IDLE
- expect_data  input  1  sampled with rx_req; 1 = expect DATA0/DATA1, 0 = expect handshake (ACK/NAK/STALL)
- rec_start  output  1  one-cycle arm pulse to the DP/DM decoder
- crc_sending  input  1  CRC16 stage bit-valid; high for one contiguous burst per packet
- crc_out_bit  input  1  serial bit, LSB first (PID then payload; CRC not forwarded)
- crc_residue_ok  input  1  residue check; valid in the cycle after crc_sending falls
- rx_busy  output  1  high in every state except IDLE
- rx_done  output  1  one-cycle completion pulse
- rx_ok  output  1  valid with rx_done; 1 when rx_err_code == 0
- rx_err_code  output  3  0 none, 1 timeout, 2 PID check, 3 CRC, 4 length, 5 unexpected PID
- rx_pid  output  4  PID[3:0] of the last packet
- rx_data  output  DATA_BITS  payload; first received bit in bit 0

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
- Reset also clears all counters and shift registers.
- All outputs reset to 0.
- Reset during RECV discards the partial packet; no rx_done is issued.

State machine IDLE -> ARM -> WAIT -> RECV -> CHECK -> DONE -> IDLE:
- IDLE: on rx_req = 1, latch expect_data and go to ARM. rx_req in any other state is ignored.
- ARM: rec_start = 1 for exactly this cycle. Clear bit_cnt (7 bits), tmo_cnt (8 bits) and the overflow flag. Go to WAIT.
- WAIT: if crc_sending = 1, capture the bit and go to RECV.
  - Otherwise tmo_cnt increments.
  - When tmo_cnt == TIMEOUT_CYCLES-1 with crc_sending still 0: err = 1, go to DONE.
  - Timeout therefore fires TIMEOUT_CYCLES+1 cycles after rec_start.
- RECV: each cycle with crc_sending = 1 captures one bit.
  - Bits 0..7 shift right into pid_sr[7:0] (new bit enters at MSB).
  - Bits 8..8+DATA_BITS-1 shift right into data_sr.
  - Beyond 8+DATA_BITS bits: set the overflow flag, stop shifting, bit_cnt saturates.
  - When crc_sending falls: go to CHECK.
- CHECK (crc_residue_ok sampled here). Error priority, highest first:
  - PID check: pid_sr[7:4] != ~pid_sr[3:0], or bit_cnt < 8 -> err = 2.
  - Unexpected PID: class mismatch -> err = 5.
    - DATA class = {0011 DATA0, 1011 DATA1}.
    - Handshake class = {0010 ACK, 1010 NAK, 1110 STALL}.
  - Length -> err = 4.
    - Data packet: bit_cnt != 8+DATA_BITS, or overflow.
    - Handshake: bit_cnt != 8.
  - CRC: data packet with crc_residue_ok = 0 -> err = 3. crc_residue_ok is ignored for handshakes.
  - Go to DONE.
- DONE: rx_done = 1 for one cycle with rx_ok and rx_err_code.
  - rx_pid and rx_data update here; on timeout they update to 0.
  - rx_pid/rx_data/rx_err_code hold until the next DONE.
  - Return to IDLE; a new rx_req is accepted in the following cycle at the earliest.
- Gaps: a crc_sending low during RECV always ends the packet; no gaps are tolerated.
- Width rules: bit_cnt counts to 72 and saturates at 73. tmo_cnt is 8 bits; TIMEOUT_CYCLES must be <= 256.

Decomposition:
- Shared package usb_pkg holds:
  - the PID constants (DATA0, DATA1, ACK, NAK, STALL);
  - the rx_err_t enum (NONE, TIMEOUT, PID_ERR, CRC_ERR, LEN_ERR, UNEXP_PID);
  - the rx_state_t enum.
- One sub-module: rx_deser (PID/data shift registers, bit_cnt, overflow flag), driven by the FSM.

Test Plan:
- DATA0: rx_req with expect_data = 1, then PID 0xC3 plus payload 0xCAFEF00D_DEADBEEF, crc_residue_ok = 1.
  -> One rec_start pulse 1 cycle after rx_req; rx_done with rx_ok = 1, err = 0, rx_pid = 3, rx_data = 0xCAFEF00D_DEADBEEF.
- ACK: expect_data = 0, 8-bit burst of PID 0xD2, crc_residue_ok = 0 -> rx_ok = 1, rx_pid = 2.
- Timeout: rx_req, crc_sending held 0 -> rx_done exactly 256 cycles after rec_start, err = 1, rx_pid = 0.
- Integrity/class errors:
  - PID 0xC2 -> err = 2.
  - DATA1 0x4B sent while expecting a handshake -> err = 5.
  - DATA0 with crc_residue_ok = 0 -> err = 3.
- Length: DATA0 with a 40-bit payload -> err = 4. DATA0 with an 80-bit payload -> err = 4, and data_sr holds the first 64 payload bits.
- Reset and busy rules:
  - reset_n low mid-RECV -> all outputs 0 immediately, no rx_done.
  - Next rx_req receives a good packet normally.
  - rx_req asserted during RECV is ignored.

Source files
------------

// File: rtl/usb_pkg.sv
// usb_pkg: PID constants, error codes and sequencer states shared by the receive path.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    RX_NONE      = 3'd0,
    RX_TIMEOUT   = 3'd1,
    RX_PID_ERR   = 3'd2,
    RX_CRC_ERR   = 3'd3,
    RX_LEN_ERR   = 3'd4,
    RX_UNEXP_PID = 3'd5
  } rx_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_RECV,
    ST_CHECK,
    ST_DONE
  } rx_state_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic is_hs_pid(input logic [3:0] pid);
    return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// rx_packet_ctrl_if: request/status and decoder-chain signals of the receive sequencer.
// Latency: not applicable (wiring only).
// Backpressure: none; the chain streams one bit per cycle while crc_sending is high.
// Ports: master = protocol handler / decoder chain side, slave = rx_packet_ctrl.
interface rx_packet_ctrl_if
  import usb_pkg::*;
#(
  parameter int DATA_BITS = 64
);
  logic                 rx_req;
  logic                 expect_data;
  logic                 rec_start;
  logic                 crc_sending;
  logic                 crc_out_bit;
  logic                 crc_residue_ok;
  logic                 rx_busy;
  logic                 rx_done;
  logic                 rx_ok;
  rx_err_t              rx_err_code;
  logic [3:0]           rx_pid;
  logic [DATA_BITS-1:0] rx_data;

  modport master (
    output rx_req, expect_data, crc_sending, crc_out_bit, crc_residue_ok,
    input  rec_start, rx_busy, rx_done, rx_ok, rx_err_code, rx_pid, rx_data
  );

  modport slave (
    input  rx_req, expect_data, crc_sending, crc_out_bit, crc_residue_ok,
    output rec_start, rx_busy, rx_done, rx_ok, rx_err_code, rx_pid, rx_data
  );
endinterface

// File: rtl/rx_deser.sv
// rx_deser: splits the serial bit stream into an 8-bit PID and a DATA_BITS payload.
// Latency: each bit lands in its shift register on the clock edge that samples it.
// Backpressure: none; excess bits set the overflow flag and are dropped.
// Ports: i_clr restarts a packet, i_shift/i_bit capture one bit; o_* expose the
//        shift registers, the saturating bit count and the overflow flag.
module rx_deser #(
  parameter int DATA_BITS = 64,
  parameter int CNT_W     = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_clr,
  input  logic                 i_shift,
  input  logic                 i_bit,
  output logic [7:0]           o_pid_sr,
  output logic [DATA_BITS-1:0] o_data_sr,
  output logic [CNT_W-1:0]     o_bit_cnt,
  output logic                 o_ovf
);
  localparam logic [CNT_W-1:0] PID_BITS  = CNT_W'(8);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(8 + DATA_BITS);
  localparam logic [CNT_W-1:0] SAT_BITS  = CNT_W'(9 + DATA_BITS);

  logic [7:0]           r_pid_sr;
  logic [DATA_BITS-1:0] r_data_sr;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pid_sr  <= '0;
      r_data_sr <= '0;
      r_bit_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (i_clr) begin
      r_pid_sr  <= '0;
      r_data_sr <= '0;
      r_bit_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (i_shift) begin
      // LSB-first stream: new bits enter at the MSB so the first bit ends in bit 0.
      if (r_bit_cnt < PID_BITS) begin
        r_pid_sr <= {i_bit, r_pid_sr[7:1]};
      end else if (r_bit_cnt < FULL_BITS) begin
        r_data_sr <= {i_bit, r_data_sr[DATA_BITS-1:1]};
      end
      // One past full marks "too long" without needing a wider counter.
      if (r_bit_cnt < FULL_BITS) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end else begin
        r_bit_cnt <= SAT_BITS;
        r_ovf     <= 1'b1;
      end
    end
  end

  assign o_pid_sr  = r_pid_sr;
  assign o_data_sr = r_data_sr;
  assign o_bit_cnt = r_bit_cnt;
  assign o_ovf     = r_ovf;
endmodule

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: arms the DP/DM->NRZI->unstuff->CRC16 chain, collects one packet and grades it.
// Latency: rec_start 1 cycle after rx_req; rx_done 2 cycles after crc_sending falls,
//          or TIMEOUT_CYCLES+1 cycles after rec_start if no bit arrives.
// Backpressure: none; rx_req is ignored while rx_busy is high.
// Ports: clock, reset_n (async, active-low); bus = slave side of rx_packet_ctrl_if.
module rx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_BITS      = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  rx_packet_ctrl_if.slave bus
);
  localparam int               CNT_W     = $clog2(DATA_BITS + 10);
  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PID_BITS  = CNT_W'(8);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(8 + DATA_BITS);

  rx_state_t            r_state;
  logic                 r_expect_data;
  logic [7:0]           r_tmo_cnt;
  logic                 r_rec_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ok;
  rx_err_t              r_err;
  logic [3:0]           r_pid;
  logic [DATA_BITS-1:0] r_data;

  logic                 w_deser_clr;
  logic                 w_deser_shift;
  logic [7:0]           w_pid_sr;
  logic [DATA_BITS-1:0] w_data_sr;
  logic [CNT_W-1:0]     w_bit_cnt;
  logic                 w_ovf;
  logic                 w_pid_intact;
  logic                 w_class_ok;
  logic                 w_len_ok;
  rx_err_t              w_chk_err;

  assign w_deser_clr   = (r_state == ST_ARM);
  assign w_deser_shift = bus.crc_sending && ((r_state == ST_WAIT) || (r_state == ST_RECV));

  rx_deser #(
    .DATA_BITS (DATA_BITS),
    .CNT_W     (CNT_W)
  ) u_deser (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clr     (w_deser_clr),
    .i_shift   (w_deser_shift),
    .i_bit     (bus.crc_out_bit),
    .o_pid_sr  (w_pid_sr),
    .o_data_sr (w_data_sr),
    .o_bit_cnt (w_bit_cnt),
    .o_ovf     (w_ovf)
  );

  assign w_pid_intact = (w_pid_sr[7:4] == ~w_pid_sr[3:0]) && (w_bit_cnt >= PID_BITS);
  assign w_class_ok   = r_expect_data ? is_data_pid(w_pid_sr[3:0]) : is_hs_pid(w_pid_sr[3:0]);
  assign w_len_ok     = r_expect_data ? ((w_bit_cnt == FULL_BITS) && !w_ovf)
                                      : (w_bit_cnt == PID_BITS);

  // Highest-priority failure wins; the CRC residue only matters for data packets.
  always_comb begin
    w_chk_err = RX_NONE;
    if (!w_pid_intact) begin
      w_chk_err = RX_PID_ERR;
    end else if (!w_class_ok) begin
      w_chk_err = RX_UNEXP_PID;
    end else if (!w_len_ok) begin
      w_chk_err = RX_LEN_ERR;
    end else if (r_expect_data && !bus.crc_residue_ok) begin
      w_chk_err = RX_CRC_ERR;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_expect_data <= 1'b0;
      r_tmo_cnt     <= '0;
      r_rec_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ok          <= 1'b0;
      r_err         <= RX_NONE;
      r_pid         <= '0;
      r_data        <= '0;
    end else begin
      r_rec_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_req) begin
            r_expect_data <= bus.expect_data;
            r_rec_start   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_ARM;
          end
        end
        ST_ARM: begin
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.crc_sending) begin
            r_state <= ST_RECV;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_done  <= 1'b1;
            r_ok    <= 1'b0;
            r_err   <= RX_TIMEOUT;
            r_pid   <= '0;
            r_data  <= '0;
            r_state <= ST_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        ST_RECV: begin
          if (!bus.crc_sending) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_done  <= 1'b1;
          r_ok    <= (w_chk_err == RX_NONE);
          r_err   <= w_chk_err;
          r_pid   <= w_pid_sr[3:0];
          r_data  <= w_data_sr;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rec_start   = r_rec_start;
  assign bus.rx_busy     = r_busy;
  assign bus.rx_done     = r_done;
  assign bus.rx_ok       = r_ok;
  assign bus.rx_err_code = r_err;
  assign bus.rx_pid      = r_pid;
  assign bus.rx_data     = r_data;
endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb_rx_packet_ctrl: directed and randomized receives graded by a rule-level reference model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_rx_packet_ctrl;

  typedef struct {
    logic [2:0]  err;
    logic [3:0]  pid;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  bit   pkt_q[$];
  exp_t exp_q[$];
  logic [7:0] pid_tab [8];

  rx_packet_ctrl_if #(.DATA_BITS(64)) bus ();

  rx_packet_ctrl #(
    .TIMEOUT_CYCLES (255),
    .DATA_BITS      (64)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rx_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.rx_done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_err",  64'(bus.rx_err_code), 64'(e.err));
        chk("done_ok",   64'(bus.rx_ok), 64'(e.err == 3'd0));
        chk("done_pid",  64'(bus.rx_pid), 64'(e.pid));
        chk("done_data", bus.rx_data, e.data);
      end
    end
  end

  // Packet content: PID byte then plen payload bits, all LSB first.
  task automatic build(input logic [7:0] pid, input logic [63:0] pay, input int plen);
    pkt_q.delete();
    for (int i = 0; i < 8; i++) pkt_q.push_back(pid[i]);
    for (int i = 0; i < plen; i++) pkt_q.push_back((i < 64) ? pay[i] : 1'($urandom));
  endtask

  // Expected outcome derived from the received bit list and the stated grading rules.
  function automatic exp_t model(input bit exp_data, input bit crc_ok);
    exp_t        e;
    int          n;
    int          k;
    int          m;
    logic [7:0]  pid;
    logic [63:0] d;
    n   = pkt_q.size();
    pid = '0;
    d   = '0;
    if (n == 0) begin
      e.err  = 3'd1;
      e.pid  = 4'd0;
      e.data = 64'd0;
      return e;
    end
    k = (n < 8) ? n : 8;
    m = (n > 8) ? (((n - 8) > 64) ? 64 : (n - 8)) : 0;
    for (int i = 0; i < k; i++) pid[8 - k + i] = pkt_q[i];
    for (int j = 0; j < m; j++) d[64 - m + j] = pkt_q[8 + j];
    e.pid  = pid[3:0];
    e.data = d;
    if (n < 8 || pid[7:4] != ~pid[3:0])
      e.err = 3'd2;
    else if (exp_data ? !(pid[3:0] == 4'h3 || pid[3:0] == 4'hB)
                      : !(pid[3:0] == 4'h2 || pid[3:0] == 4'hA || pid[3:0] == 4'hE))
      e.err = 3'd5;
    else if (exp_data ? (n != 72) : (n != 8))
      e.err = 3'd4;
    else if (exp_data && !crc_ok)
      e.err = 3'd3;
    else
      e.err = 3'd0;
    return e;
  endfunction

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    while (lat < limit) begin
      @(negedge clk);
      lat++;
      if (bus.rx_done === 1'b1) break;
    end
  endtask

  // One full receive of whatever is in pkt_q; an empty pkt_q exercises the timeout.
  task automatic run_rx(input bit exp_data, input bit crc_ok, input bit poke_req);
    exp_t e;
    int   lat;
    e = model(exp_data, crc_ok);
    @(negedge clk);
    bus.rx_req      = 1'b1;
    bus.expect_data = exp_data;
    @(negedge clk);
    bus.rx_req      = 1'b0;
    bus.expect_data = 1'($urandom);
    chk("rec_start_pulse", 64'(bus.rec_start), 64'd1);
    chk("busy_active", 64'(bus.rx_busy), 64'd1);
    exp_q.push_back(e);
    if (pkt_q.size() == 0) begin
      wait_done(400, lat);
      chk("timeout_latency", 64'(lat), 64'd256);
    end else begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      chk("rec_start_single", 64'(bus.rec_start), 64'd0);
      for (int i = 0; i < pkt_q.size(); i++) begin
        bus.crc_sending = 1'b1;
        bus.crc_out_bit = pkt_q[i];
        bus.rx_req      = poke_req && (i == pkt_q.size() / 2);
        @(negedge clk);
      end
      bus.crc_sending    = 1'b0;
      bus.rx_req         = 1'b0;
      bus.crc_residue_ok = crc_ok;
      wait_done(20, lat);
      chk("done_latency", 64'(lat), 64'd2);
    end
    @(negedge clk);
    chk("busy_idle", 64'(bus.rx_busy), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rec_start"}, 64'(bus.rec_start), 64'd0);
    chk({tag, "_busy"},      64'(bus.rx_busy), 64'd0);
    chk({tag, "_done"},      64'(bus.rx_done), 64'd0);
    chk({tag, "_ok"},        64'(bus.rx_ok), 64'd0);
    chk({tag, "_err"},       64'(bus.rx_err_code), 64'd0);
    chk({tag, "_pid"},       64'(bus.rx_pid), 64'd0);
    chk({tag, "_data"},      bus.rx_data, 64'd0);
  endtask

  initial begin
    logic [7:0]  pid;
    logic [63:0] pay;
    int          plen;
    int          trunc;
    bit          ed;
    bit          ok;

    pid_tab = '{8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'hC2, 8'h69, 8'h00};

    rst_n              = 1'b0;
    bus.rx_req         = 1'b0;
    bus.expect_data    = 1'b0;
    bus.crc_sending    = 1'b0;
    bus.crc_out_bit    = 1'b0;
    bus.crc_residue_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DATA0 good packet
    build(8'hC3, 64'hCAFEF00D_DEADBEEF, 64);
    run_rx(1'b1, 1'b1, 1'b0);
    // ACK handshake, residue flag ignored
    build(8'hD2, 64'd0, 0);
    run_rx(1'b0, 1'b0, 1'b0);
    // timeout
    pkt_q.delete();
    run_rx(1'b1, 1'b1, 1'b0);
    // PID complement broken
    build(8'hC2, 64'd0, 0);
    run_rx(1'b0, 1'b1, 1'b0);
    // DATA1 while expecting a handshake
    build(8'h4B, 64'h0123_4567_89AB_CDEF, 64);
    run_rx(1'b0, 1'b1, 1'b0);
    // DATA0 with CRC residue failure
    build(8'hC3, 64'h1122_3344_5566_7788, 64);
    run_rx(1'b1, 1'b0, 1'b0);
    // short and long payloads
    build(8'hC3, 64'h0000_00AB_CDEF_1234, 40);
    run_rx(1'b1, 1'b1, 1'b0);
    build(8'hC3, 64'hFEDC_BA98_7654_3210, 80);
    run_rx(1'b1, 1'b1, 1'b0);

    // Reset in the middle of a burst: outputs clear at once, no completion follows.
    build(8'hC3, 64'hA5A5_5A5A_0F0F_F0F0, 64);
    @(negedge clk);
    bus.rx_req      = 1'b1;
    bus.expect_data = 1'b1;
    @(negedge clk);
    bus.rx_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.crc_sending = 1'b1;
      bus.crc_out_bit = pkt_q[i];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midrecv_reset");
    @(negedge clk);
    bus.crc_sending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    build(8'hC3, 64'hCAFEF00D_DEADBEEF, 64);
    run_rx(1'b1, 1'b1, 1'b0);

    // rx_req pulsed during the burst must not restart anything
    build(8'h4B, 64'h5555_AAAA_3333_CCCC, 64);
    run_rx(1'b1, 1'b1, 1'b1);

    // randomized receives
    for (int t = 0; t < 40; t++) begin
      pid  = pid_tab[$urandom_range(0, 7)];
      if (pid == 8'h00) pid = 8'($urandom);
      pay  = {32'($urandom), 32'($urandom)};
      ed   = 1'($urandom);
      ok   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        plen = $urandom_range(0, 80);
      else
        plen = (pid[3:0] == 4'h3 || pid[3:0] == 4'hB) ? 64 : 0;
      build(pid, pay, plen);
      if ($urandom_range(0, 9) == 0) begin
        trunc = $urandom_range(1, 7);
        while (pkt_q.size() > trunc) void'(pkt_q.pop_back());
      end
      run_rx(ed, ok, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
